// File: rtl/bf_bus_responder_if.sv
// Shared bus-operation encoding and the interpreter-side bus interface.
// The interpreter drives the operation, address and write data; the
// responder answers with read data and the interpreter's clock-enable.

package bf_bus_pkg;

  typedef enum logic [2:0] {
    BUS_NONE       = 3'd0,
    BUS_READ_PROG  = 3'd1,
    BUS_READ_DATA  = 3'd2,
    BUS_WRITE_DATA = 3'd3,
    BUS_READ_IO    = 3'd4,
    BUS_WRITE_IO   = 3'd5
  } bus_op_e;

endpackage

interface bf_bus_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int BUS_WIDTH  = 8
);
  import bf_bus_pkg::*;

  bus_op_e                bus_op;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [BUS_WIDTH-1:0]   val_out;
  logic [BUS_WIDTH-1:0]   val_in;
  logic                   enable;

  // Interpreter side.
  modport master (
    output bus_op, addr, val_out,
    input  val_in, enable
  );

  // Responder side.
  modport slave (
    input  bus_op, addr, val_out,
    output val_in, enable
  );

endinterface

// File: rtl/bf_bus_responder.sv
// Target side of the BF interpreter bus. Program and data accesses go to a
// single external synchronous SRAM (region bit selects program/data), IO
// reads consume an input byte stream and IO writes fill an output FIFO.
// The interpreter is stalled through enable whenever IO cannot complete.

module bf_bus_responder
  import bf_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int BUS_WIDTH  = 8,
  parameter int OUT_DEPTH  = 4,
  parameter int CNT_WIDTH  = $clog2(OUT_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  bf_bus_if.slave               bus,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  fifo_count
);

  localparam int PTR_WIDTH = $clog2(OUT_DEPTH);

  typedef enum logic {
    S_RUN,
    S_MEMRD
  } state_e;

  state_e                 state, state_nx;
  logic [BUS_WIDTH-1:0]   val_hold;
  logic [BUS_WIDTH-1:0]   val_in_c;

  logic [7:0]             fifo_mem [OUT_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]   fifo_cnt;

  logic op_rd_prog, op_rd_data, op_wr_data, op_rd_io, op_wr_io;
  logic is_mem_rd, full, stall, accept, push, pop;

  // Operation decode; unknown encodings match nothing and act as BUS_NONE.
  assign op_rd_prog = (bus.bus_op == BUS_READ_PROG);
  assign op_rd_data = (bus.bus_op == BUS_READ_DATA);
  assign op_wr_data = (bus.bus_op == BUS_WRITE_DATA);
  assign op_rd_io   = (bus.bus_op == BUS_READ_IO);
  assign op_wr_io   = (bus.bus_op == BUS_WRITE_IO);
  assign is_mem_rd  = op_rd_prog | op_rd_data;

  // Full looks only at the registered count, so a same-cycle pop never
  // lets a push through; this keeps the push path free of the sink's ready.
  assign full   = (fifo_cnt == CNT_WIDTH'(OUT_DEPTH));
  assign stall  = (op_rd_io & ~in_valid) | (op_wr_io & full);
  assign accept = run & ~stall;

  assign bus.enable = accept;
  assign bus.val_in = val_in_c;

  // SRAM access: memory operations never stall, so they only need run.
  assign mem_en    = run & (op_rd_prog | op_rd_data | op_wr_data);
  assign mem_we    = op_wr_data;
  assign mem_addr  = {~op_rd_prog, bus.addr};
  assign mem_wdata = bus.val_out;

  assign in_ready = run & op_rd_io & in_valid;

  assign push       = accept & op_wr_io;
  assign pop        = out_valid & out_ready;
  assign out_valid  = (fifo_cnt != '0);
  assign out_data   = fifo_mem[rd_ptr];
  assign fifo_count = fifo_cnt;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours regardless of block ordering.
    if (!reset_n) state <= S_RUN;
    else          state <= state_nx;
  end

  // Next-state and read-data mux: a memory read result is passed straight
  // through in S_MEMRD, otherwise the held value is presented.
  always_comb begin
    // NOTE: defaults first so no path through the block leaves an output
    // unassigned, which would otherwise infer a latch.
    state_nx = state;
    val_in_c = val_hold;
    case (state)
      S_RUN: begin
        if (accept && is_mem_rd) state_nx = S_MEMRD;
      end
      S_MEMRD: begin
        val_in_c = mem_rdata;
        state_nx = (accept && is_mem_rd) ? S_MEMRD : S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  // Held read value: an IO byte wins, otherwise the SRAM word is captured
  // whenever a read result is on the bus, so val_in stays stable after a stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               val_hold <= '0;
    else if (in_ready)          val_hold <= BUS_WIDTH'(in_data);
    else if (state == S_MEMRD)  val_hold <= mem_rdata;
  end

  // FIFO storage; only the pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately not reset; an empty count makes
    // stale contents invisible, and leaving it out keeps it a plain RAM.
    if (push) fifo_mem[wr_ptr] <= bus.val_out[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_WIDTH'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_WIDTH'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: doc/bf_bus_responder.md
Name: bf_bus_responder

Overview:
- Target side of the BF interpreter bus: decodes bus_op/addr/val_out and returns val_in plus the interpreter's enable.
- Maps program and data accesses onto one external synchronous SRAM (1-cycle read latency).
- Maps IO reads to an input valid/ready stream and IO writes into an output FIFO.
- Stalls the interpreter via enable when IO cannot complete.

Parameters:
- ADDR_WIDTH, 15, width of the interpreter bus address.
- BUS_WIDTH, 8, width of the bus data (val_in/val_out, mem data).
- OUT_DEPTH, 4, output FIFO entries; power of two, >=2.
- CNT_WIDTH, $clog2(OUT_DEPTH)+1, width of fifo_count.

Ports:
- clock  in  1  single clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  host run request; gates enable and memory access.
- bus_op  in  BusOp  operation from interpreter (BusNone/ReadProg/ReadData/WriteData/ReadIo/WriteIo).
- addr  in  ADDR_WIDTH  bus address.
- val_out  in  BUS_WIDTH  write data from interpreter.
- val_in  out  BUS_WIDTH  read data to interpreter.
- enable  out  1  interpreter clock-enable.
- mem_en  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write.
- mem_addr  out  ADDR_WIDTH+1  {region, addr}; region 0 = program, 1 = data.
- mem_wdata  out  BUS_WIDTH  SRAM write data.
- mem_rdata  in  BUS_WIDTH  SRAM read data, valid the cycle after mem_en & !mem_we.
- in_data  in  8  input byte stream.
- in_valid  in  1  input byte available.
- in_ready  out  1  input byte consumed this cycle.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts head.
- fifo_count  out  CNT_WIDTH  current FIFO occupancy.

Behaviour:
- Reset (async, reset_n=0):
  - State S_RUN; val_hold=0; FIFO empty (count 0, pointers 0).
  - Resulting outputs: val_in=0, out_valid=0, fifo_count=0.
  - enable, mem_en and in_ready are combinational and evaluate to 0 only via run/bus_op.
  - A pending SRAM read is dropped; reset mid-operation loses no state beyond this.
- accept = run & !stall.
- stall = (bus_op==BusReadIo & !in_valid) | (bus_op==BusWriteIo & full).
- enable = accept, combinational.
- Memory ops:
  - mem_en = run & bus_op in {BusReadProg, BusReadData, BusWriteData}.
  - mem_we = (bus_op==BusWriteData).
  - mem_addr = {bus_op!=BusReadProg, addr}; mem_wdata = val_out.
  - Memory ops never stall.
- FSM, 2 states:
  - S_RUN: val_in = val_hold. Accepted BusReadProg/BusReadData -> S_MEMRD; else stay.
  - S_MEMRD: val_in = mem_rdata (combinational pass-through); val_hold <= mem_rdata at clock edge. Accepted memory read -> stay S_MEMRD; else -> S_RUN.
  - val_in is stable across an enable/run drop: the captured val_hold is shown from the next cycle on.
- IO read:
  - in_ready = run & bus_op==BusReadIo & in_valid.
  - On that cycle val_hold <= in_data (zero-extended to BUS_WIDTH); state -> S_RUN.
  - The interpreter sees the byte on val_in the following cycle.
- IO write:
  - When accepted, push val_out[7:0] to FIFO tail.
  - full uses registered count == OUT_DEPTH; a push while full is stalled even if a pop occurs the same cycle.
- FIFO pop:
  - Occurs when out_valid & out_ready; out_data = entry at head.
  - Push into an empty FIFO gives out_valid=1 next cycle.
  - Simultaneous push and pop (not full) leaves count unchanged.
  - Pointers wrap modulo OUT_DEPTH.
- run=0: enable=0, mem_en=0, in_ready=0; FIFO still drains to sink; val_hold unchanged.
- BusNone or unknown encoding: no side effects, enable=run.

Test Plan:
- Program-read timing: preload SRAM prog[0x0005]=0x2B; bus_op=BusReadProg, addr=5, run=1 -> mem_en=1, mem_addr=0x0005, enable=1; next cycle val_in=0x2B; cycle after with bus_op=BusNone val_in still 0x2B.
- Data write/read: BusWriteData addr=3 val_out=0x7F -> mem_we=1, mem_addr={1,3}; then BusReadData addr=3 -> val_in=0x7F one cycle later.
- IO read stall: BusReadIo with in_valid=0 for 5 cycles -> enable=0, in_ready=0. Then in_valid=1, in_data=0x41 -> in_ready=1, enable=1 that cycle; next cycle val_in=0x41.
- FIFO full: out_ready=0; issue 5 BusWriteIo of 0x10..0x14 -> first 4 accepted, fifo_count=4, 5th holds enable=0. Raise out_ready -> 0x10 pops; 5th write accepted next cycle; drain order 0x10..0x14.
- Reset mid-operation: reset_n low during S_MEMRD with 3 FIFO entries -> out_valid=0, fifo_count=0, val_in=0 immediately; after release, a normal program read works.
- Run drop: accept BusReadData (cell=0x99), drop run in the following cycle -> enable=0; val_in remains 0x99 for all held cycles.
